keypad_scan_datapath: RTL and testbench
=======================================

KEYPAD_SCAN_DATAPATH -- requirements
Module: keypad_scan_datapath

Interface
REQ-001 Parameter SCAN_DWELL, default 1000, clk cycles each column is driven before advancing (>=2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 100000, clk cycles of stable press required (>=2).
REQ-003 clk  input  1  single system clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 rows  input  4  raw keypad row lines, asynchronous, active-low (0 = key pressed on the driven column).
REQ-006 scan_counter_en  input  1  control-FSM enable for column scanning.
REQ-007 WE_synch  input  1  control-FSM strobe: capture the current column/row snapshot.
REQ-008 debounce_counter_en  input  1  control-FSM enable for the debounce counter.
REQ-009 check_again  input  1  control-FSM re-check phase indicator.
REQ-010 WE_send  input  1  control-FSM strobe: publish the decoded key.
REQ-011 cols  output  4  column drive, one-hot active-low.
REQ-012 buttonpush  output  1  any synchronized row low.
REQ-013 synch_done  output  1  snapshot captured.
REQ-014 debounce_done  output  1  debounce interval elapsed.
REQ-015 post_debounce  output  1  press still present and identical to the snapshot.
REQ-016 key_code  output  4  last published hex key value.
REQ-017 key_valid  output  1  one-cycle pulse marking a new key_code.

Function
REQ-018 rows SHALL pass through a 2-flop synchronizer (row_sync); no other logic SHALL use raw rows.
REQ-019 buttonpush SHALL be combinational: 1 when row_sync != 4'b1111.
REQ-020 Dwell counter SHALL increment while scan_counter_en=1; at SCAN_DWELL-1 it SHALL wrap to 0 and cols SHALL rotate 1110->1101->1011->0111->1110.
REQ-021 While scan_counter_en=0 the dwell counter and cols SHALL hold their values (column frozen).
REQ-022 On any cycle with WE_synch=1, snap_col<=cols and snap_row<=row_sync SHALL be registered.
REQ-023 synch_done SHALL be WE_synch delayed by one registered cycle (first assertion 1 cycle after WE_synch rises).
REQ-024 Debounce counter SHALL increment while debounce_counter_en=1, saturating at DEBOUNCE_CYCLES-1; it SHALL clear to 0 on any cycle debounce_counter_en=0.
REQ-025 debounce_done SHALL be combinational: 1 when the debounce counter equals DEBOUNCE_CYCLES-1.
REQ-026 post_debounce SHALL be combinational: 1 only when row_sync==snap_row, cols==snap_col, and snap_row has exactly one 0 bit.
REQ-027 Multiple rows low in the snapshot (multi-key) SHALL force post_debounce=0, causing rejection.
REQ-028 On WE_send=1, key_code SHALL load the decode of {snap_row, snap_col}, and key_valid SHALL be 1 on the following cycle only.
REQ-029 Decode (row r, col c, index 0 = LSB low): r0: 1 2 3 A; r1: 4 5 6 B; r2: 7 8 9 C; r3: E 0 F D.
REQ-030 An invalid snapshot at WE_send SHALL leave key_code unchanged and SHALL suppress key_valid.
REQ-031 WE_send held for N cycles SHALL produce exactly one key_valid pulse (rising-edge detect).
REQ-032 check_again SHALL not alter state; it is accepted for interface completeness only.
REQ-033 Counter widths SHALL be $clog2 of their parameter, with no overflow at the limit values.

Reset
REQ-034 While reset=0: cols=4'b1110, dwell and debounce counters=0, synchronizer flops=1111, snap_row=1111, snap_col=1110, synch_done=0, key_code=0, key_valid=0.
REQ-035 Reset asserted mid-operation (any counter non-zero or snapshot held) SHALL return all state to REQ-034 values immediately, with no key_valid pulse.
REQ-036 After reset deasserts, scanning SHALL resume from cols=1110 on the first cycle with scan_counter_en=1.

Verification (SCAN_DWELL=4, DEBOUNCE_CYCLES=8)
REQ-037 Idle scan: rows=1111, scan_counter_en=1 for 20 cycles -> cols steps 1110,1101,1011,0111,1110 every 4 cycles; buttonpush=0.
REQ-038 Key "6": rows=1101 while cols=1011; FSM-style strobes WE_synch, 8-cycle debounce, WE_send -> synch_done 1 cycle after WE_synch, debounce_done after 8 enabled cycles, post_debounce=1, key_code=4'h6, single key_valid pulse.
REQ-039 Bounce: rows return to 1111 during debounce before the check -> post_debounce=0, key_code unchanged, no key_valid.
REQ-040 Two keys: rows=1100 captured -> post_debounce=0; WE_send forced anyway -> no key_valid, key_code held.
REQ-041 Reset mid-debounce (counter=5) -> counter=0, cols=1110, key_code=0, debounce_done=0.
REQ-042 WE_send held 3 cycles for key "D" (rows=0111, cols=0111) -> key_code=4'hD, exactly one key_valid pulse.

Source files
------------

// File: rtl/keypad_scan_datapath.sv
// ---------------------------------------------------------------------------
// keypad_scan_datapath
//
// Datapath for a 4x4 matrix keypad scanner. An external control FSM drives
// the strobes. This block does the following:
//   * rotates a one-hot active-low column drive, holding each column for
//     SCAN_DWELL clocks while scanning is enabled;
//   * synchronizes the raw row lines through two flops;
//   * captures a column/row snapshot on request;
//   * times a debounce interval;
//   * reports whether the press still matches the snapshot;
//   * decodes and publishes the key as a hex code with a one-cycle valid pulse.
//
// Ports:
//   clk                 in   system clock, all state on posedge
//   reset               in   asynchronous reset, active low
//   rows[3:0]           in   raw row lines, asynchronous, active low
//   scan_counter_en     in   advance the column dwell counter
//   WE_synch            in   capture the current column/row snapshot
//   debounce_counter_en in   run the debounce counter (clears when low)
//   check_again         in   control-FSM phase indicator, no effect here
//   WE_send             in   publish the decoded snapshot (edge detected)
//   cols[3:0]           out  column drive, one-hot active low
//   buttonpush          out  some synchronized row is low
//   synch_done          out  WE_synch delayed one clock
//   debounce_done       out  debounce counter at its terminal value
//   post_debounce       out  press unchanged and snapshot holds a single key
//   key_code[3:0]       out  last published key
//   key_valid           out  one-cycle pulse with each new key_code
// ---------------------------------------------------------------------------
module keypad_scan_datapath #(
    parameter int SCAN_DWELL      = 1000,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    input  logic       scan_counter_en,
    input  logic       WE_synch,
    input  logic       debounce_counter_en,
    input  logic       check_again,
    input  logic       WE_send,
    output logic [3:0] cols,
    output logic       buttonpush,
    output logic       synch_done,
    output logic       debounce_done,
    output logic       post_debounce,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int DWELL_W = $clog2(SCAN_DWELL);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES);

    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DWELL - 1);
    localparam logic [DWELL_W-1:0] DWELL_ONE  = DWELL_W'(1);
    localparam logic [DWELL_W-1:0] DWELL_ZERO = {DWELL_W{1'b0}};
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [DEB_W-1:0]   DEB_ONE    = DEB_W'(1);
    localparam logic [DEB_W-1:0]   DEB_ZERO   = {DEB_W{1'b0}};

    localparam logic [3:0] ROWS_IDLE = 4'b1111;
    localparam logic [3:0] COL_FIRST = 4'b1110;

    // -----------------------------------------------------------------------
    // Helper functions
    // -----------------------------------------------------------------------

    // True when exactly one bit of an active-low 4-bit group is asserted.
    function automatic logic single_low(input logic [3:0] v);
        logic r;
        case (v)
            4'b1110: r = 1'b1;
            4'b1101: r = 1'b1;
            4'b1011: r = 1'b1;
            4'b0111: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Position of the single low bit. Only meaningful when single_low() holds.
    function automatic logic [1:0] low_pos(input logic [3:0] v);
        logic [1:0] p;
        case (v)
            4'b1110: p = 2'd0;
            4'b1101: p = 2'd1;
            4'b1011: p = 2'd2;
            4'b0111: p = 2'd3;
            default: p = 2'd0;
        endcase
        return p;
    endfunction

    // Keypad legend: row index selects the line, column index the key.
    // The bottom row carries '*' (E), 0, '#' (F) and D.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'b00_00: k = 4'h1;
            4'b00_01: k = 4'h2;
            4'b00_10: k = 4'h3;
            4'b00_11: k = 4'hA;
            4'b01_00: k = 4'h4;
            4'b01_01: k = 4'h5;
            4'b01_10: k = 4'h6;
            4'b01_11: k = 4'hB;
            4'b10_00: k = 4'h7;
            4'b10_01: k = 4'h8;
            4'b10_10: k = 4'h9;
            4'b10_11: k = 4'hC;
            4'b11_00: k = 4'hE;
            4'b11_01: k = 4'h0;
            4'b11_10: k = 4'hF;
            4'b11_11: k = 4'hD;
            default:  k = 4'h0;
        endcase
        return k;
    endfunction

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [3:0]         sync1_q;
    logic [3:0]         sync2_q;
    logic [DWELL_W-1:0] dwell_q,    dwell_d;
    logic [3:0]         cols_q,     cols_d;
    logic [3:0]         snap_row_q, snap_row_d;
    logic [3:0]         snap_col_q, snap_col_d;
    logic               synch_done_q;
    logic [DEB_W-1:0]   deb_q,      deb_d;
    logic               send_prev_q;
    logic [3:0]         key_code_q, key_code_d;
    logic               key_valid_q, key_valid_d;

    logic [3:0] row_sync_s;
    logic       snap_valid_s;
    logic       send_rise_s;
    logic       unused_check_again_s;

    // check_again only marks a control-FSM phase. The datapath behaves the
    // same in that phase, so the input is accepted and left unused.
    assign unused_check_again_s = check_again;

    assign row_sync_s   = sync2_q;
    assign snap_valid_s = single_low(snap_row_q) & single_low(snap_col_q);
    assign send_rise_s  = WE_send & ~send_prev_q;

    // Two-flop synchronizer for the asynchronous row lines.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= ROWS_IDLE;
            sync2_q <= ROWS_IDLE;
        end else begin
            sync1_q <= rows;
            sync2_q <= sync1_q;
        end
    end

    // Column scan: count the dwell, then rotate the active-low column on wrap.
    always_comb begin
        dwell_d = dwell_q;
        cols_d  = cols_q;
        if (scan_counter_en) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d = DWELL_ZERO;
                cols_d  = {cols_q[2:0], cols_q[3]};
            end else begin
                dwell_d = dwell_q + DWELL_ONE;
                cols_d  = cols_q;
            end
        end else begin
            dwell_d = dwell_q;
            cols_d  = cols_q;
        end
    end

    // Snapshot capture of the driven column and synchronized rows.
    always_comb begin
        snap_row_d = snap_row_q;
        snap_col_d = snap_col_q;
        if (WE_synch) begin
            snap_row_d = row_sync_s;
            snap_col_d = cols_q;
        end else begin
            snap_row_d = snap_row_q;
            snap_col_d = snap_col_q;
        end
    end

    // Debounce timer: saturates at its terminal count and clears when disabled.
    always_comb begin
        deb_d = deb_q;
        if (debounce_counter_en) begin
            if (deb_q == DEB_LAST) begin
                deb_d = deb_q;
            end else begin
                deb_d = deb_q + DEB_ONE;
            end
        end else begin
            deb_d = DEB_ZERO;
        end
    end

    // Publish on the rising edge of WE_send, so a held strobe yields one
    // pulse. A snapshot with no key or several keys is silently dropped.
    always_comb begin
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        if (send_rise_s && snap_valid_s) begin
            key_code_d  = key_lookup(low_pos(snap_row_q), low_pos(snap_col_q));
            key_valid_d = 1'b1;
        end else begin
            key_code_d  = key_code_q;
            key_valid_d = 1'b0;
        end
    end

    // Sequential state for scan, snapshot, debounce and key publication.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dwell_q      <= DWELL_ZERO;
            cols_q       <= COL_FIRST;
            snap_row_q   <= ROWS_IDLE;
            snap_col_q   <= COL_FIRST;
            synch_done_q <= 1'b0;
            deb_q        <= DEB_ZERO;
            send_prev_q  <= 1'b0;
            key_code_q   <= 4'h0;
            key_valid_q  <= 1'b0;
        end else begin
            dwell_q      <= dwell_d;
            cols_q       <= cols_d;
            snap_row_q   <= snap_row_d;
            snap_col_q   <= snap_col_d;
            synch_done_q <= WE_synch;
            deb_q        <= deb_d;
            send_prev_q  <= WE_send;
            key_code_q   <= key_code_d;
            key_valid_q  <= key_valid_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign cols          = cols_q;
    assign buttonpush    = (row_sync_s != ROWS_IDLE);
    assign synch_done    = synch_done_q;
    assign debounce_done = (deb_q == DEB_LAST);
    // The press must be unchanged on both axes, and the snapshot must hold a
    // single key. A multi-key snapshot always fails and is rejected.
    assign post_debounce = (row_sync_s == snap_row_q) && (cols_q == snap_col_q) && snap_valid_s;
    assign key_code      = key_code_q;
    assign key_valid     = key_valid_q;

endmodule

// File: tb/tb_keypad_scan_datapath.sv
`timescale 1ns/1ps
module tb_keypad_scan_datapath;

    localparam int SD = 4;
    localparam int DC = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] rows = 4'b1111;
    logic       scan_counter_en = 1'b0;
    logic       WE_synch = 1'b0;
    logic       debounce_counter_en = 1'b0;
    logic       check_again = 1'b0;
    logic       WE_send = 1'b0;
    logic [3:0] cols;
    logic       buttonpush;
    logic       synch_done;
    logic       debounce_done;
    logic       post_debounce;
    logic [3:0] key_code;
    logic       key_valid;

    keypad_scan_datapath #(.SCAN_DWELL(SD), .DEBOUNCE_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .rows(rows),
        .scan_counter_en(scan_counter_en), .WE_synch(WE_synch),
        .debounce_counter_en(debounce_counter_en), .check_again(check_again),
        .WE_send(WE_send), .cols(cols), .buttonpush(buttonpush),
        .synch_done(synch_done), .debounce_done(debounce_done),
        .post_debounce(post_debounce), .key_code(key_code), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] code;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc_cnt = 0;

    // Reference model state, kept at the level of "what has happened so far".
    int         en_count;
    int         run;
    logic [3:0] m_r1;
    logic [3:0] m_rs;
    logic [3:0] m_snap_row;
    logic [3:0] m_snap_col;
    logic [3:0] m_key;
    logic       m_sd;
    logic       m_prev_send;
    logic [3:0] key_tbl [16];

    // Column currently driven: one column per SD enabled clocks, cycling 0..3.
    function automatic logic [3:0] exp_cols();
        int idx;
        logic [3:0] one;
        idx = (en_count / SD) % 4;
        one = 4'b0001;
        return ~(one << idx);
    endfunction

    // Index of the only low bit, or -1 if there is not exactly one.
    function automatic int low_index(input logic [3:0] v);
        int n;
        int pos;
        n = 0;
        pos = -1;
        for (int i = 0; i < 4; i++) begin
            if (v[i] == 1'b0) begin
                n++;
                pos = i;
            end
        end
        return (n == 1) ? pos : -1;
    endfunction

    function automatic logic exp_post();
        return (m_rs == m_snap_row) && (exp_cols() == m_snap_col) && (low_index(m_snap_row) >= 0);
    endfunction

    task automatic model_reset();
        en_count = 0;
        run = 0;
        m_r1 = 4'b1111;
        m_rs = 4'b1111;
        m_snap_row = 4'b1111;
        m_snap_col = 4'b1110;
        m_key = 4'h0;
        m_sd = 1'b0;
        m_prev_send = 1'b0;
        sb.delete();
    endtask

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc_cnt, act, expv);
        end
    endtask

    // Advance the model by one clock edge, using the inputs present at that edge.
    task automatic model_step();
        logic [3:0] oc;
        int         r;
        int         c;
        exp_t       e;
        oc = exp_cols();
        if (WE_send && !m_prev_send) begin
            r = low_index(m_snap_row);
            c = low_index(m_snap_col);
            if (r >= 0 && c >= 0) begin
                m_key = key_tbl[r * 4 + c];
                e.code = m_key;
                e.cyc = cyc_cnt;
                sb.push_back(e);
            end
        end
        if (WE_synch) begin
            m_snap_col = oc;
            m_snap_row = m_rs;
        end
        m_sd = WE_synch;
        if (scan_counter_en) en_count++;
        if (debounce_counter_en) run++;
        else run = 0;
        m_prev_send = WE_send;
        m_rs = m_r1;
        m_r1 = rows;
    endtask

    task automatic check_all();
        chk("cols", cols, exp_cols());
        chk("buttonpush", {3'b000, buttonpush}, {3'b000, (m_rs != 4'b1111)});
        chk("synch_done", {3'b000, synch_done}, {3'b000, m_sd});
        chk("debounce_done", {3'b000, debounce_done}, {3'b000, (run >= DC - 1)});
        chk("post_debounce", {3'b000, post_debounce}, {3'b000, exp_post()});
        chk("key_code", key_code, m_key);
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc_cnt++;
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        chk("rst_cols", cols, 4'b1110);
        chk("rst_synch_done", {3'b000, synch_done}, 4'b0000);
        chk("rst_debounce_done", {3'b000, debounce_done}, 4'b0000);
        chk("rst_key_code", key_code, 4'h0);
        chk("rst_key_valid", {3'b000, key_valid}, 4'b0000);
        chk("rst_buttonpush", {3'b000, buttonpush}, 4'b0000);
        chk("rst_post_debounce", {3'b000, post_debounce}, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            cyc_cnt++;
        end
        #1;
        reset = 1'b1;
    endtask

    // Scan until the wanted column is driven, then freeze scanning.
    task automatic goto_col(input logic [3:0] target);
        int n;
        n = 0;
        while (exp_cols() != target && n < 64) begin
            scan_counter_en = 1'b1;
            cycle();
            n++;
        end
        scan_counter_en = 1'b0;
        chk("goto_col", cols, target);
    endtask

    // Scoreboard monitor: every key_valid pulse must match a queued expectation.
    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset === 1'b1) begin
                if (key_valid === 1'b1) begin
                    total++;
                    if (sb.size() == 0) begin
                        bad++;
                        $display("FAIL key_valid_unexpected cyc=%0d got=1 want=0 code=%h", cyc_cnt, key_code);
                    end else begin
                        e = sb.pop_front();
                        if (key_code !== e.code || e.cyc != cyc_cnt) begin
                            bad++;
                            $display("FAIL key_pulse cyc=%0d got=%h want=%h at cyc %0d", cyc_cnt, key_code, e.code, e.cyc);
                        end
                    end
                end else if (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
                    total++;
                    bad++;
                    $display("FAIL key_valid_missing cyc=%0d got=0 want=1 code=%h", cyc_cnt, sb[0].code);
                    e = sb.pop_front();
                end
            end
        end
    endtask

    task automatic press_and_capture(input logic [3:0] r);
        rows = r;
        repeat (3) cycle();
        WE_synch = 1'b1;
        cycle();
        chk("synch_done_rise", {3'b000, synch_done}, 4'b0001);
        WE_synch = 1'b0;
    endtask

    initial begin
        key_tbl = '{4'h1, 4'h2, 4'h3, 4'hA,
                    4'h4, 4'h5, 4'h6, 4'hB,
                    4'h7, 4'h8, 4'h9, 4'hC,
                    4'hE, 4'h0, 4'hF, 4'hD};
        model_reset();
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Idle scan
        rows = 4'b1111;
        scan_counter_en = 1'b1;
        repeat (20) cycle();
        scan_counter_en = 1'b0;
        cycle();

        // Key "6": row 1 on column 2
        goto_col(4'b1011);
        press_and_capture(4'b1101);
        chk("key6_buttonpush", {3'b000, buttonpush}, 4'b0001);
        debounce_counter_en = 1'b1;
        repeat (8) cycle();
        chk("key6_debounce_done", {3'b000, debounce_done}, 4'b0001);
        chk("key6_post_debounce", {3'b000, post_debounce}, 4'b0001);
        WE_send = 1'b1;
        cycle();
        WE_send = 1'b0;
        debounce_counter_en = 1'b0;
        repeat (2) cycle();
        chk("key6_code", key_code, 4'h6);

        // Bounce: release during debounce
        press_and_capture(4'b1101);
        debounce_counter_en = 1'b1;
        repeat (3) cycle();
        rows = 4'b1111;
        repeat (5) cycle();
        chk("bounce_post_debounce", {3'b000, post_debounce}, 4'b0000);
        debounce_counter_en = 1'b0;
        cycle();
        chk("bounce_key_held", key_code, 4'h6);

        // Two keys in the snapshot, publish forced anyway
        press_and_capture(4'b1100);
        cycle();
        chk("multi_post_debounce", {3'b000, post_debounce}, 4'b0000);
        WE_send = 1'b1;
        cycle();
        WE_send = 1'b0;
        repeat (2) cycle();
        chk("multi_key_held", key_code, 4'h6);
        rows = 4'b1111;

        // Reset in the middle of debounce
        scan_counter_en = 1'b1;
        repeat (6) cycle();
        scan_counter_en = 1'b0;
        debounce_counter_en = 1'b1;
        repeat (5) cycle();
        chk("middeb_not_done", {3'b000, debounce_done}, 4'b0000);
        do_reset();
        debounce_counter_en = 1'b0;
        scan_counter_en = 1'b1;
        repeat (5) cycle();
        scan_counter_en = 1'b0;

        // Key "D" with WE_send held for three cycles
        goto_col(4'b0111);
        press_and_capture(4'b0111);
        debounce_counter_en = 1'b1;
        repeat (8) cycle();
        WE_send = 1'b1;
        repeat (3) cycle();
        WE_send = 1'b0;
        debounce_counter_en = 1'b0;
        repeat (2) cycle();
        chk("keyD_code", key_code, 4'hD);
        rows = 4'b1111;
        cycle();

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            int sel;
            sel = $urandom_range(0, 9);
            if (sel < 4) begin
                rows = 4'b1111;
                rows[sel] = 1'b0;
            end else if (sel < 6) begin
                rows = 4'($urandom_range(0, 15));
            end else begin
                rows = 4'b1111;
            end
            scan_counter_en = ($urandom_range(0, 3) != 0);
            debounce_counter_en = ($urandom_range(0, 4) != 0);
            WE_synch = ($urandom_range(0, 7) == 0);
            WE_send = ($urandom_range(0, 4) == 0);
            check_again = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end
            cycle();
        end
        rows = 4'b1111;
        scan_counter_en = 1'b0;
        debounce_counter_en = 1'b0;
        WE_synch = 1'b0;
        WE_send = 1'b0;
        repeat (3) cycle();
        @(negedge clk);
        chk("sb_drained", 4'(sb.size()), 4'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
